// File: rtl/fifo_arb_pkg.sv
// Shared types and limits for the FIFO write-port arbiter (fifo_wr_arbiter).
package fifo_arb_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } arb_state_e;

   localparam int unsigned MAX_BURST_LIMIT = 255;
   localparam int unsigned BEAT_CNT_W      = 8;

   // Width of a requester index; never below one bit.
   function automatic int unsigned id_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: the search starts just after last_grant_i and wraps.
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter  int unsigned NUM_REQ = 4,
   localparam int unsigned ID_W    = id_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [ID_W-1:0]    last_grant_i,
   output logic               found_o,
   output logic [ID_W-1:0]    winner_o
);

   int unsigned best_dist;

   // Distance of requester j from the search start in round-robin order.
   function automatic int unsigned rr_dist(input int unsigned j, input logic [ID_W-1:0] last);
      return (j + (2 * NUM_REQ) - 32'(last) - 1) % NUM_REQ;
   endfunction

   always_comb begin
      found_o   = 1'b0;
      winner_o  = '0;
      best_dist = NUM_REQ;
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
         if (req_i[j] && (rr_dist(j, last_grant_i) < best_dist)) begin
            found_o   = 1'b1;
            winner_o  = ID_W'(j);
            best_dist = rr_dist(j, last_grant_i);
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter driving the async FIFO write port.
// Define FIFO_ARB_TAG_EN to prefix each written beat with the owner's id.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter  int unsigned NUM_REQ    = 4,
   parameter  int unsigned DATA_WIDTH = 8,
   parameter  int unsigned MAX_BURST  = 4,
   localparam int unsigned ID_W       = id_width(NUM_REQ),
`ifdef FIFO_ARB_TAG_EN
   localparam int unsigned FIFO_W     = DATA_WIDTH + ID_W
`else
   localparam int unsigned FIFO_W     = DATA_WIDTH
`endif
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ-1:0]            req_last,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic                          w_en,
   output logic [FIFO_W-1:0]             wdata,
   input  logic                          w_full,
   input  logic                          w_almost_full,
   output logic [ID_W-1:0]               grant_id,
   output logic                          busy
);

   localparam int unsigned BURST_CAP = (MAX_BURST > MAX_BURST_LIMIT) ? MAX_BURST_LIMIT :
                                       ((MAX_BURST < 1) ? 1 : MAX_BURST);
   localparam logic [BEAT_CNT_W-1:0] BEAT_LAST = BEAT_CNT_W'(BURST_CAP - 1);

   arb_state_e              state_q, state_d;
   logic [ID_W-1:0]         owner_q, owner_d;
   logic [ID_W-1:0]         last_grant_q, last_grant_d;
   logic [BEAT_CNT_W-1:0]   beat_cnt_q, beat_cnt_d;

   logic                    pick_found;
   logic [ID_W-1:0]         pick_winner;
   logic                    own_valid;
   logic                    own_last;
   logic [DATA_WIDTH-1:0]   own_data;
   logic                    beat_acc;

   rr_pick #(
      .NUM_REQ(NUM_REQ)
   ) u_rr_pick (
      .req_i       (req_valid),
      .last_grant_i(last_grant_q),
      .found_o     (pick_found),
      .winner_o    (pick_winner)
   );

   // Owner's view of its stream.
   always_comb begin
      own_valid = 1'b0;
      own_last  = 1'b0;
      own_data  = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (owner_q == ID_W'(i)) begin
            own_valid = req_valid[i];
            own_last  = req_last[i];
            own_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign beat_acc = (state_q == ST_BURST) && own_valid && !w_full;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         owner_q      <= '0;
         last_grant_q <= ID_W'(NUM_REQ - 1);
         beat_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         beat_cnt_q   <= beat_cnt_d;
      end
   end

   // Next-state: grant in IDLE, count beats and close the burst in BURST.
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      beat_cnt_d   = beat_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (pick_found && !w_almost_full) begin
               state_d      = ST_BURST;
               owner_d      = pick_winner;
               last_grant_d = pick_winner;
               beat_cnt_d   = '0;
            end
         end
         ST_BURST: begin
            if (beat_acc) begin
               if (own_last || (beat_cnt_q == BEAT_LAST)) begin
                  state_d    = ST_IDLE;
                  beat_cnt_d = '0;
               end else begin
                  beat_cnt_d = beat_cnt_q + BEAT_CNT_W'(1);
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Zero-latency write path from the registered owner.
   always_comb begin
      req_ready = '0;
      w_en      = beat_acc;
      wdata     = '0;
      if (state_q == ST_BURST) begin
         for (int unsigned i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = (owner_q == ID_W'(i)) && !w_full;
         end
`ifdef FIFO_ARB_TAG_EN
         wdata = {owner_q, own_data};
`else
         wdata = own_data;
`endif
      end
   end

   assign busy     = (state_q == ST_BURST);
   assign grant_id = owner_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter (NUM_REQ=4, DATA_WIDTH=8, MAX_BURST=4).
module tb_fifo_wr_arbiter;

   localparam int unsigned NR = 4;
   localparam int unsigned DW = 8;
`ifdef FIFO_ARB_TAG_EN
   localparam int unsigned FW = DW + 2;
`else
   localparam int unsigned FW = DW;
`endif

   typedef struct packed {
      logic [1:0]    id;
      logic [DW-1:0] data;
   } beat_t;

   logic            clk;
   logic            rst;
   logic [NR-1:0]   req_valid;
   logic [NR-1:0]   req_last;
   logic [NR*DW-1:0] req_data;
   logic [NR-1:0]   req_ready;
   logic            w_en;
   logic [FW-1:0]   wdata;
   logic            w_full;
   logic            w_almost_full;
   logic [1:0]      grant_id;
   logic            busy;

   fifo_wr_arbiter #(
      .NUM_REQ   (NR),
      .DATA_WIDTH(DW),
      .MAX_BURST (4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_last     (req_last),
      .req_data     (req_data),
      .req_ready    (req_ready),
      .w_en         (w_en),
      .wdata        (wdata),
      .w_full       (w_full),
      .w_almost_full(w_almost_full),
      .grant_id     (grant_id),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [8:0]  rq [NR][$];
   beat_t       exp_q[$];
   int          wen_cyc[$];
   int          cyc;
   int          n_checks;
   int          n_fail;

   logic          s_busy;
   logic          s_wen;
   logic [NR-1:0] s_ready;
   logic [1:0]    s_gid;
   logic [FW-1:0] s_wdata;

   // One clock: drive requester heads at negedge, sample, score writes, retire accepted beats.
   task automatic cycle(input logic full, input logic afull, input logic rst_v);
      logic [NR-1:0] acc;
      beat_t         e;
      @(negedge clk);
      rst           = rst_v;
      w_full        = full;
      w_almost_full = afull;
      for (int i = 0; i < NR; i++) begin
         if (rq[i].size() > 0) begin
            req_valid[i]        = 1'b1;
            req_last[i]         = rq[i][0][8];
            req_data[i*DW +: DW] = rq[i][0][7:0];
         end else begin
            req_valid[i]        = 1'b0;
            req_last[i]         = 1'b0;
            req_data[i*DW +: DW] = '0;
         end
      end
      #1;
      s_busy  = busy;
      s_wen   = w_en;
      s_ready = req_ready;
      s_gid   = grant_id;
      s_wdata = wdata;
      if (w_en === 1'b1) begin
         wen_cyc.push_back(cyc);
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected_write: cyc %0d got data %h id %0d, required no write", cyc, wdata[DW-1:0], grant_id);
         end else begin
            e = exp_q.pop_front();
            if (wdata[DW-1:0] !== e.data || grant_id !== e.id) begin
               n_fail++;
               $display("FAIL sb_beat: cyc %0d got data %h id %0d, required data %h id %0d", cyc, wdata[DW-1:0], grant_id, e.data, e.id);
            end
`ifdef FIFO_ARB_TAG_EN
            n_checks++;
            if (wdata[DW +: 2] !== e.id) begin
               n_fail++;
               $display("FAIL sb_tag: cyc %0d got tag %0d, required %0d", cyc, wdata[DW +: 2], e.id);
            end
`endif
         end
      end
      acc = req_valid & req_ready;
      @(posedge clk);
      for (int i = 0; i < NR; i++) begin
         if (acc[i] && rq[i].size() > 0) void'(rq[i].pop_front());
      end
      cyc++;
   endtask

   task automatic apply_reset();
      for (int i = 0; i < NR; i++) rq[i].delete();
      exp_q.delete();
      cycle(1'b0, 1'b0, 1'b1);
      cycle(1'b0, 1'b0, 1'b1);
      cyc = 0;
      wen_cyc.delete();
   endtask

   task automatic push_beat(input int r, input logic [7:0] d, input logic l);
      beat_t e;
      rq[r].push_back({l, d});
      e.id   = 2'(r);
      e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic test_reset();
      apply_reset();
      rq[0].push_back({1'b1, 8'h11});
      cycle(1'b0, 1'b0, 1'b1);
      n_checks++;
      if (s_busy !== 1'b0 || s_gid !== 2'd0 || s_wen !== 1'b0 || s_ready !== 4'b0 || s_wdata !== '0) begin
         n_fail++;
         $display("FAIL reset_state: got busy %b gid %0d w_en %b ready %b wdata %h, required all 0",
                  s_busy, s_gid, s_wen, s_ready, s_wdata);
      end
   endtask

   task automatic test_single();
      apply_reset();
      push_beat(2, 8'hA0, 1'b0);
      push_beat(2, 8'hA1, 1'b0);
      push_beat(2, 8'hA2, 1'b1);
      for (int c = 0; c < 6; c++) begin
         cycle(1'b0, 1'b0, 1'b0);
         if (c == 0 || c == 1 || c == 4) begin
            n_checks++;
            if (s_busy !== ((c == 1) ? 1'b1 : 1'b0)) begin
               n_fail++;
               $display("FAIL single_busy: cyc %0d got %b, required %b", c, s_busy, (c == 1));
            end
         end
      end
      n_checks++;
      if (wen_cyc.size() != 3) begin
         n_fail++;
         $display("FAIL single_wen_count: got %0d, required 3", wen_cyc.size());
      end else begin
         for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (wen_cyc[k] != k + 1) begin
               n_fail++;
               $display("FAIL single_wen_cycle: beat %0d got cyc %0d, required %0d", k, wen_cyc[k], k + 1);
            end
         end
      end
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL single_drain: got %0d beats left, required 0", exp_q.size());
      end
   endtask

   task automatic test_fairness();
      apply_reset();
      push_beat(0, 8'h00, 1'b1);
      push_beat(1, 8'h10, 1'b1);
      push_beat(2, 8'h20, 1'b1);
      push_beat(3, 8'h30, 1'b1);
      push_beat(0, 8'h01, 1'b1);
      for (int c = 0; c < 12; c++) cycle(1'b0, 1'b0, 1'b0);
      n_checks++;
      if (wen_cyc.size() != 5) begin
         n_fail++;
         $display("FAIL fair_wen_count: got %0d, required 5", wen_cyc.size());
      end else begin
         for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (wen_cyc[k] != 2 * k + 1) begin
               n_fail++;
               $display("FAIL fair_bubble: grant %0d got cyc %0d, required %0d", k, wen_cyc[k], 2 * k + 1);
            end
         end
      end
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL fair_drain: got %0d beats left, required 0", exp_q.size());
      end
   endtask

   task automatic test_burst_cap();
      int exp_cyc [11];
      beat_t e;
      apply_reset();
      for (int k = 0; k < 4; k++) push_beat(1, 8'(8'h40 + k), 1'b0);
      e.id = 2'd3; e.data = 8'h70;
      exp_q.push_back(e);
      rq[3].push_back({1'b1, 8'h70});
      for (int k = 4; k < 10; k++) push_beat(1, 8'(8'h40 + k), 1'b0);
      exp_cyc = '{1, 2, 3, 4, 6, 8, 9, 10, 11, 13, 14};
      for (int c = 0; c < 18; c++) cycle(1'b0, 1'b0, 1'b0);
      n_checks++;
      if (wen_cyc.size() != 11) begin
         n_fail++;
         $display("FAIL cap_wen_count: got %0d, required 11", wen_cyc.size());
      end else begin
         for (int k = 0; k < 11; k++) begin
            n_checks++;
            if (wen_cyc[k] != exp_cyc[k]) begin
               n_fail++;
               $display("FAIL cap_wen_cycle: beat %0d got cyc %0d, required %0d", k, wen_cyc[k], exp_cyc[k]);
            end
         end
      end
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL cap_drain: got %0d beats left, required 0", exp_q.size());
      end
   endtask

   task automatic test_backpressure();
      int exp_cyc [6];
      logic full;
      apply_reset();
      for (int k = 0; k < 5; k++) push_beat(0, 8'(8'h50 + k), 1'b0);
      push_beat(0, 8'h55, 1'b1);
      exp_cyc = '{1, 2, 6, 7, 9, 10};
      for (int c = 0; c < 13; c++) begin
         full = (c >= 3 && c <= 5);
         cycle(full, 1'b0, 1'b0);
         if (full) begin
            n_checks++;
            if (s_ready !== 4'b0 || s_wen !== 1'b0 || s_busy !== 1'b1) begin
               n_fail++;
               $display("FAIL bp_stall: cyc %0d got ready %b w_en %b busy %b, required 0000 0 1", c, s_ready, s_wen, s_busy);
            end
         end
         if (c == 8) begin
            n_checks++;
            if (s_busy !== 1'b0) begin
               n_fail++;
               $display("FAIL bp_cap_after_stall: cyc 8 got busy %b, required 0", s_busy);
            end
         end
      end
      n_checks++;
      if (wen_cyc.size() != 6) begin
         n_fail++;
         $display("FAIL bp_wen_count: got %0d, required 6", wen_cyc.size());
      end else begin
         for (int k = 0; k < 6; k++) begin
            n_checks++;
            if (wen_cyc[k] != exp_cyc[k]) begin
               n_fail++;
               $display("FAIL bp_wen_cycle: beat %0d got cyc %0d, required %0d", k, wen_cyc[k], exp_cyc[k]);
            end
         end
      end
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL bp_drain: got %0d beats left, required 0", exp_q.size());
      end
   endtask

   task automatic test_almost_full();
      logic afull;
      apply_reset();
      push_beat(0, 8'h60, 1'b0);
      push_beat(0, 8'h61, 1'b0);
      push_beat(0, 8'h62, 1'b1);
      for (int c = 0; c < 10; c++) begin
         afull = (c < 4) || (c >= 6);
         cycle(1'b0, afull, 1'b0);
         if (c <= 4) begin
            n_checks++;
            if (s_busy !== 1'b0 || s_wen !== 1'b0) begin
               n_fail++;
               $display("FAIL af_block: cyc %0d got busy %b w_en %b, required 0 0", c, s_busy, s_wen);
            end
         end
      end
      n_checks++;
      if (wen_cyc.size() != 3) begin
         n_fail++;
         $display("FAIL af_wen_count: got %0d, required 3", wen_cyc.size());
      end else begin
         for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (wen_cyc[k] != k + 5) begin
               n_fail++;
               $display("FAIL af_wen_cycle: beat %0d got cyc %0d, required %0d", k, wen_cyc[k], k + 5);
            end
         end
      end
   endtask

   task automatic test_reset_mid_burst();
      int exp_cyc [5];
      beat_t e;
      apply_reset();
      rq[1].push_back({1'b0, 8'h80});
      rq[1].push_back({1'b0, 8'h81});
      rq[1].push_back({1'b0, 8'h82});
      rq[1].push_back({1'b1, 8'h83});
      e.id = 2'd1;
      e.data = 8'h80; exp_q.push_back(e);
      e.data = 8'h81; exp_q.push_back(e);
      e.data = 8'h82; exp_q.push_back(e);
      cycle(1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b1);
      rq[0].push_back({1'b1, 8'h90});
      e.id = 2'd0; e.data = 8'h90; exp_q.push_back(e);
      e.id = 2'd1; e.data = 8'h83; exp_q.push_back(e);
      cycle(1'b0, 1'b0, 1'b0);
      n_checks++;
      if (s_wen !== 1'b0 || s_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL rmb_drop: got w_en %b busy %b, required 0 0", s_wen, s_busy);
      end
      cycle(1'b0, 1'b0, 1'b0);
      n_checks++;
      if (s_busy !== 1'b1 || s_gid !== 2'd0) begin
         n_fail++;
         $display("FAIL rmb_regrant: got busy %b gid %0d, required 1 0", s_busy, s_gid);
      end
      for (int c = 0; c < 4; c++) cycle(1'b0, 1'b0, 1'b0);
      exp_cyc = '{1, 2, 3, 5, 7};
      n_checks++;
      if (wen_cyc.size() != 5) begin
         n_fail++;
         $display("FAIL rmb_wen_count: got %0d, required 5", wen_cyc.size());
      end else begin
         for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (wen_cyc[k] != exp_cyc[k]) begin
               n_fail++;
               $display("FAIL rmb_wen_cycle: beat %0d got cyc %0d, required %0d", k, wen_cyc[k], exp_cyc[k]);
            end
         end
      end
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL rmb_drain: got %0d beats left, required 0", exp_q.size());
      end
   endtask

   initial begin
      n_checks      = 0;
      n_fail        = 0;
      cyc           = 0;
      rst           = 1'b1;
      req_valid     = '0;
      req_last      = '0;
      req_data      = '0;
      w_full        = 1'b0;
      w_almost_full = 1'b0;
      test_reset();
      test_single();
      test_fairness();
      test_burst_cap();
      test_backpressure();
      test_almost_full();
      test_reset_mid_burst();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin burst arbiter that shares the single write port of the team's asynchronous FIFO among `NUM_REQ` requesters in the write clock domain. Each requester presents a valid/ready/last beat stream. The arbiter grants one requester a whole burst, which ends on `last` or after `MAX_BURST` beats. It drives the FIFO `w_en`/`wdata` directly and honours the FIFO's `w_full` and `w_almost_full` flags.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters (2..16).
- `DATA_WIDTH`, default 8: payload width per beat.
- `MAX_BURST`, default 4: maximum beats per grant (1..255).
- `ID_W` (localparam) = max(1, $clog2(`NUM_REQ`)).
- `FIFO_W` (localparam) = `DATA_WIDTH` + `ID_W` with tagging enabled, otherwise `DATA_WIDTH`.

Ports:
- `clk`  in  1  write-domain clock (same clock as the FIFO `wclk`).
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  `NUM_REQ`  per-requester beat valid.
- `req_last`  in  `NUM_REQ`  marks the final beat of a requester's burst.
- `req_data`  in  `NUM_REQ`*`DATA_WIDTH`  packed payloads; requester i uses bits [i*`DATA_WIDTH` +: `DATA_WIDTH`].
- `req_ready`  out  `NUM_REQ`  per-requester beat accept.
- `w_en`  out  1  FIFO write enable.
- `wdata`  out  `FIFO_W`  FIFO write data.
- `w_full`  in  1  FIFO full flag.
- `w_almost_full`  in  1  FIFO almost-full flag.
- `grant_id`  out  `ID_W`  current owner; meaningful only while `busy`=1.
- `busy`  out  1  high in the BURST state.

## Operation
- The FSM has two states, IDLE and BURST.
- IDLE:
  - If any `req_valid` is high and `w_almost_full`=0, pick the winner by round-robin and go to BURST next cycle.
  - Otherwise stay in IDLE.
- Round-robin search starts at `last_grant`+1 and wraps modulo `NUM_REQ`. The lowest index found in that order wins. `last_grant` updates to the winner when the grant is taken.
- BURST, with owner g:
  - `req_ready[g]` = ~`w_full`. All other `req_ready` are 0.
  - `w_en` = `req_valid[g]` & ~`w_full`.
  - `wdata` = payload g, prefixed by the tag when tagging is enabled.
  - A beat is accepted when `w_en`=1. Each accepted beat increments `beat_cnt`.
- A burst ends on the accepted beat where `req_last[g]`=1 or `beat_cnt`=`MAX_BURST`-1. The FSM then goes to IDLE and `beat_cnt` clears.
- Owner drops `req_valid` mid-burst: the grant is held, no beat is written, and `beat_cnt` holds. There is no timeout.
- `w_full` mid-burst: `req_ready[g]`=0 and `w_en`=0, and state and count hold.
- `w_almost_full` only blocks the start of a new burst. It does not affect a burst already in progress. `w_full` prevents overflow.
- `beat_cnt` is 8 bits wide and never wraps, because the burst ends at `MAX_BURST`-1.
- In IDLE, `w_en`=0 and every `req_ready`=0.

## Timing
- Reset values: state=IDLE, `last_grant`=`NUM_REQ`-1 (so requester 0 wins first), `beat_cnt`=0, `busy`=0, `grant_id`=0. `w_en`, `req_ready` and `wdata` are all 0.
- Grant latency: a request seen in IDLE at edge k puts the arbiter in BURST at edge k+1. The first beat can be accepted in the cycle after edge k+1.
- `w_en`, `req_ready` and `wdata` are combinational from the registered state/owner, `req_valid`, `req_data` and `w_full`. This gives zero-cycle beat latency.
- There is one IDLE bubble cycle between bursts. An L-beat burst occupies L+1 cycles with no stalls.
- Reset asserted mid-burst: at the next edge the arbiter enters IDLE and `w_en`=0 from that edge. A partial burst is not completed.
- Simultaneous `req_last` and `beat_cnt`=`MAX_BURST`-1: a single burst end.

## Configuration
- `FIFO_ARB_TAG_EN` defined: `wdata` = {`grant_id`, payload}, `FIFO_W`=`DATA_WIDTH`+`ID_W`. This lets the read side demultiplex beats.
- Not defined: `wdata` = payload only, `FIFO_W`=`DATA_WIDTH`. The FIFO `DATA_WIDTH` must be instantiated to match `FIFO_W`.

## Structure
- Package `fifo_arb_pkg`: FSM state enum (IDLE, BURST) and the `MAX_BURST` range limit constant.
- Sub-module `rr_pick`: combinational round-robin picker. Inputs are the request vector and the last-grant index; outputs are `found` and the winner index. The FSM, counter and output muxing stay in the top module.

## Test plan
Use `NUM_REQ`=4, `DATA_WIDTH`=8, `MAX_BURST`=4, FIFO depth 16.
- Reset then a single requester: req 2 sends 3 beats 0xA0..0xA2 with last on 0xA2. Required: `busy` rises one cycle after valid, the three `w_en` pulses are in order, then IDLE.
- Fairness: all 4 requesters hold valid with last on every beat. Required: grants go 0,1,2,3,0 with one bubble between them.
- Burst cap: req 1 streams 10 beats and never asserts last. Required: the grant ends after exactly 4 beats; with req 3 also waiting, req 3 wins the next grant.
- Backpressure: `w_full` is forced high for 3 cycles mid-burst. Required: `req_ready`=0 and `w_en`=0 for those 3 cycles, no data loss, and `beat_cnt` holds.
- Almost full: `w_almost_full`=1 in IDLE with req 0 valid. Required: no grant until it drops. With `w_almost_full` raised mid-burst, the burst completes.
- Reset mid-burst plus the tag macro: reset after beat 2 drops `w_en` at the next edge and the next grant goes to req 0. With `FIFO_ARB_TAG_EN` defined, `wdata[9:8]` equals `grant_id` on every beat.
